// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, op/state enums and helpers for the cache line transfer engine
package cache_pkg;

    localparam int SET_BITS       = 7;
    localparam int WAY_BITS       = 2;
    localparam int WORDS_PER_LINE = 16;
    localparam int WORD_BITS      = 32;
    localparam int BLOCK_BYTES    = 64;
    localparam int IDX_BITS       = $clog2(WORDS_PER_LINE);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS_PER_LINE - 1);

    typedef enum logic {
        OP_FILL      = 1'b0,
        OP_WRITEBACK = 1'b1
    } xfer_op_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WB_RD,
        WB_CAP,
        WB_SEND,
        DONE
    } xfer_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cache_line_xfer_if.sv
// rtl/cache_line_xfer_if.sv - command, data array and memory-side bus bundle for cache_line_xfer
interface cache_line_xfer_if import cache_pkg::*; ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_op;
    logic [SET_BITS-1:0]  cmd_set;
    logic [WAY_BITS-1:0]  cmd_way;
    logic                 done;
    logic                 err;

    logic [SET_BITS-1:0]  da_set_index;
    logic [WAY_BITS-1:0]  da_way;
    logic [5:0]           da_block_offset;
    logic [1:0]           da_byte_offset;
    logic [WORD_BITS-1:0] da_write_data;
    logic [WORD_BITS-1:0] da_read_data;
    logic                 da_write;
    logic                 da_read;

    logic                 mem_rvalid;
    logic                 mem_rready;
    logic [WORD_BITS-1:0] mem_rdata;
    logic                 mem_rlast;
    logic                 mem_wvalid;
    logic                 mem_wready;
    logic [WORD_BITS-1:0] mem_wdata;
    logic                 mem_wlast;

    modport master (
        input  cmd_valid, cmd_op, cmd_set, cmd_way, da_read_data,
               mem_rvalid, mem_rdata, mem_rlast, mem_wready,
        output cmd_ready, done, err, da_set_index, da_way, da_block_offset,
               da_byte_offset, da_write_data, da_write, da_read,
               mem_rready, mem_wvalid, mem_wdata, mem_wlast
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_set, cmd_way, da_read_data,
               mem_rvalid, mem_rdata, mem_rlast, mem_wready,
        input  cmd_ready, done, err, da_set_index, da_way, da_block_offset,
               da_byte_offset, da_write_data, da_write, da_read,
               mem_rready, mem_wvalid, mem_wdata, mem_wlast
    );

endinterface

// File: rtl/cache_line_xfer_perf.sv
// rtl/cache_line_xfer_perf.sv - saturating fill/writeback/stall counters, present only with LINE_XFER_PERF_EN
`ifdef LINE_XFER_PERF_EN
module cache_line_xfer_perf import cache_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fill_inc,
    input  logic        wb_inc,
    input  logic        stall_inc,
    output logic [15:0] fill_cnt,
    output logic [15:0] wb_cnt,
    output logic [15:0] stall_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt  <= '0;
            wb_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            if (fill_inc)  fill_cnt  <= sat_inc16(fill_cnt);
            if (wb_inc)    wb_cnt    <= sat_inc16(wb_cnt);
            if (stall_inc) stall_cnt <= sat_inc16(stall_cnt);
        end
    end

endmodule
`endif

// File: rtl/cache_line_xfer.sv
// rtl/cache_line_xfer.sv - moves one cache line between data array and memory bus (FILL / WRITEBACK)
// Optional perf counters under LINE_XFER_PERF_EN.
module cache_line_xfer import cache_pkg::*; (
    input  logic               clk,
    input  logic               rst_n,
    cache_line_xfer_if.master  bus
`ifdef LINE_XFER_PERF_EN
    ,
    output logic [15:0]        perf_fill_cnt,
    output logic [15:0]        perf_wb_cnt,
    output logic [15:0]        perf_stall_cnt
`endif
);

    xfer_state_t          state;
    xfer_op_t             op_q;
    logic [SET_BITS-1:0]  set_q;
    logic [WAY_BITS-1:0]  way_q;
    logic [IDX_BITS-1:0]  word_idx;
    logic [WORD_BITS-1:0] wdata_q;
    logic                 cmd_ready_q;
    logic                 done_q;
    logic                 err_q;
    logic                 da_read_q;
    logic                 mem_rready_q;
    logic                 mem_wvalid_q;
    logic                 mem_wlast_q;
    logic                 fill_beat;

    // Fill beats go straight into the array in the cycle they arrive; rready is high only in FILL.
    assign fill_beat = mem_rready_q && bus.mem_rvalid;

    assign bus.cmd_ready       = cmd_ready_q;
    assign bus.done            = done_q;
    assign bus.err             = err_q;
    assign bus.da_set_index    = set_q;
    assign bus.da_way          = way_q;
    assign bus.da_block_offset = 6'({word_idx, 2'b00});
    assign bus.da_byte_offset  = 2'b00;
    assign bus.da_write        = fill_beat;
    assign bus.da_write_data   = fill_beat ? bus.mem_rdata : '0;
    assign bus.da_read         = da_read_q;
    assign bus.mem_rready      = mem_rready_q;
    assign bus.mem_wvalid      = mem_wvalid_q;
    assign bus.mem_wdata       = wdata_q;
    assign bus.mem_wlast       = mem_wlast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= OP_FILL;
            set_q        <= '0;
            way_q        <= '0;
            word_idx     <= '0;
            wdata_q      <= '0;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            da_read_q    <= 1'b0;
            mem_rready_q <= 1'b0;
            mem_wvalid_q <= 1'b0;
            mem_wlast_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= xfer_op_t'(bus.cmd_op);
                        set_q       <= bus.cmd_set;
                        way_q       <= bus.cmd_way;
                        err_q       <= 1'b0;
                        word_idx    <= '0;
                        cmd_ready_q <= 1'b0;
                        if (xfer_op_t'(bus.cmd_op) == OP_FILL) begin
                            state        <= FILL;
                            mem_rready_q <= 1'b1;
                        end else begin
                            state     <= WB_RD;
                            da_read_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (bus.mem_rvalid) begin
                        // rlast is only checked, never trusted: the line is always a full count of beats.
                        if (bus.mem_rlast != (word_idx == LAST_IDX)) err_q <= 1'b1;
                        if (word_idx == LAST_IDX) begin
                            state        <= DONE;
                            mem_rready_q <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            word_idx <= word_idx + IDX_BITS'(1);
                        end
                    end
                end
                WB_RD: begin
                    da_read_q <= 1'b0;
                    state     <= WB_CAP;
                end
                WB_CAP: begin
                    wdata_q      <= bus.da_read_data;
                    mem_wvalid_q <= 1'b1;
                    mem_wlast_q  <= (word_idx == LAST_IDX);
                    state        <= WB_SEND;
                end
                WB_SEND: begin
                    if (bus.mem_wready) begin
                        mem_wvalid_q <= 1'b0;
                        mem_wlast_q  <= 1'b0;
                        if (word_idx == LAST_IDX) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            word_idx  <= word_idx + IDX_BITS'(1);
                            da_read_q <= 1'b1;
                            state     <= WB_RD;
                        end
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    word_idx    <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_XFER_PERF_EN
    cache_line_xfer_perf u_perf (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill_inc  (done_q && (op_q == OP_FILL)),
        .wb_inc    (done_q && (op_q == OP_WRITEBACK)),
        .stall_inc (mem_wvalid_q && !bus.mem_wready),
        .fill_cnt  (perf_fill_cnt),
        .wb_cnt    (perf_wb_cnt),
        .stall_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_cache_line_xfer.sv
// tb/tb_cache_line_xfer.sv - vector table plus random transfers against a line-level array/bus model
module tb_cache_line_xfer;
    import cache_pkg::*;

    typedef struct {
        bit op;
        int set;
        int way;
        int rlast_beat;
        int stall_word;
        int stall_len;
        bit bubbles;
        int base;
        bit exp_err;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_line_xfer_if bus ();

`ifdef LINE_XFER_PERF_EN
    logic [15:0] perf_fill_cnt, perf_wb_cnt, perf_stall_cnt;
`endif

    cache_line_xfer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef LINE_XFER_PERF_EN
        ,
        .perf_fill_cnt  (perf_fill_cnt),
        .perf_wb_cnt    (perf_wb_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] arr     [512][16];
    logic [31:0] ref_mem [512][16];
    logic        pre_en = 1'b0;
    int          pre_line = 0;
    logic [31:0] pre_data [16];

    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, done_cnt = 0;
    int perf_fills = 0, perf_wbs = 0, perf_stalls = 0;

    // Data array model: one port, read data valid the cycle after da_read.
    always @(posedge clk) begin
        if (pre_en)
            for (int i = 0; i < 16; i++) arr[pre_line][i] <= pre_data[i];
        if (bus.da_write)
            arr[{bus.da_set_index, bus.da_way}][bus.da_block_offset[5:2]] <= bus.da_write_data;
        if (bus.da_read)
            bus.da_read_data <= arr[{bus.da_set_index, bus.da_way}][bus.da_block_offset[5:2]];
    end

    always @(negedge clk) begin
        if (bus.da_read) rd_cnt++;
        if (bus.da_write) wr_cnt++;
        if (bus.da_read && bus.da_write) both_cnt++;
        if (bus.done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit op, int set, int way, int rlast_beat, int stall_word,
                                int stall_len, bit bubbles, int base, bit exp_err);
        vec_t v;
        v.op = op; v.set = set; v.way = way; v.rlast_beat = rlast_beat;
        v.stall_word = stall_word; v.stall_len = stall_len; v.bubbles = bubbles;
        v.base = base; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic preload(input int line, input int base);
        for (int i = 0; i < 16; i++) begin
            pre_data[i] = (base >= 0) ? 32'(base + i) : $urandom;
            ref_mem[line][i] = pre_data[i];
        end
        pre_line = line;
        @(negedge clk);
        pre_en = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic send_cmd(input vec_t v);
        int budget = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_set   = 7'(v.set);
        bus.cmd_way   = 2'(v.way);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        chk("cmd_accept_ready_low", 64'(bus.cmd_ready), 64'd0);
        chk("err_cleared_on_accept", 64'(bus.err), 64'd0);
    endtask

    task automatic finish_xfer(input bit exp_err, input int done0);
        chk("done_pulse_high", 64'(bus.done), 64'd1);
        chk("err_after_xfer", 64'(bus.err), 64'(exp_err));
        @(posedge clk);
        #1;
        chk("done_pulse_low", 64'(bus.done), 64'd0);
        chk("cmd_ready_after_done", 64'(bus.cmd_ready), 64'd1);
        chk("err_sticky", 64'(bus.err), 64'(exp_err));
        @(negedge clk);
        chk("done_count", 64'(done_cnt - done0), 64'd1);
    endtask

    task automatic run_fill(input vec_t v);
        logic [31:0] d [16];
        int  line = v.set * 4 + v.way;
        int  i = 0, budget = 0, wr0, done0, mism = 0;
        bit  bubble;
        for (int k = 0; k < 16; k++) begin
            d[k] = (v.base >= 0) ? 32'(v.base + k) : $urandom;
            ref_mem[line][k] = d[k];
        end
        wr0 = wr_cnt;
        done0 = done_cnt;
        send_cmd(v);
        while (i < 16 && budget < 200) begin
            bubble = v.bubbles && ($urandom_range(0, 3) == 0);
            bus.mem_rvalid = !bubble;
            bus.mem_rdata  = bubble ? $urandom : d[i];
            bus.mem_rlast  = !bubble && (i == v.rlast_beat);
            @(negedge clk);
            if (!bubble) begin
                chk("fill_rready", 64'(bus.mem_rready), 64'd1);
                chk("fill_write_beat",
                    64'({bus.da_write, bus.da_block_offset, bus.da_write_data}),
                    64'({1'b1, 6'(i * 4), d[i]}));
            end else begin
                chk("fill_bubble_no_write", 64'(bus.da_write), 64'd0);
            end
            @(posedge clk);
            #1;
            if (!bubble) i++;
            budget++;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rlast  = 1'b0;
        if (i < 16) chk("fill_beat_budget", 64'(i), 64'd16);
        finish_xfer(v.exp_err, done0);
        chk("fill_write_count", 64'(wr_cnt - wr0), 64'd16);
        for (int k = 0; k < 16; k++)
            if (arr[line][k] !== ref_mem[line][k]) mism++;
        chk("fill_line_contents", 64'(mism), 64'd0);
        perf_fills++;
    endtask

    task automatic run_wb(input vec_t v);
        int          line = v.set * 4 + v.way;
        int          w = 0, budget = 0, stall_left = v.stall_len, rd0, wr0, done0;
        bit          first = 1'b1, hs;
        logic [32:0] held = '0;
        if (v.base >= 0) preload(line, v.base);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        done0 = done_cnt;
        send_cmd(v);
        while (w < 16 && budget < 400) begin
            // Stray fill beats and commands must be ignored mid-writeback.
            bus.mem_rvalid = 1'($urandom_range(0, 1));
            bus.mem_rdata  = $urandom;
            bus.mem_rlast  = 1'($urandom_range(0, 1));
            bus.cmd_valid  = 1'($urandom_range(0, 1));
            bus.cmd_op     = 1'($urandom_range(0, 1));
            @(negedge clk);
            hs = 1'b0;
            if (bus.mem_wvalid) begin
                if (first) begin
                    chk("wb_beat", 64'({bus.mem_wlast, bus.mem_wdata}),
                        64'({w == 15, ref_mem[line][w]}));
                    held  = {bus.mem_wlast, bus.mem_wdata};
                    first = 1'b0;
                end else begin
                    chk("wb_stall_stable", 64'({bus.mem_wlast, bus.mem_wdata}), 64'(held));
                end
                if (w == v.stall_word && stall_left > 0) begin
                    stall_left--;
                    perf_stalls++;
                end else begin
                    bus.mem_wready = 1'b1;
                    hs = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            bus.mem_wready = 1'b0;
            if (hs) begin
                w++;
                first = 1'b1;
            end
            budget++;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rlast  = 1'b0;
        bus.cmd_valid  = 1'b0;
        if (w < 16) chk("wb_beat_budget", 64'(w), 64'd16);
        finish_xfer(1'b0, done0);
        chk("wb_read_count", 64'(rd_cnt - rd0), 64'd16);
        chk("wb_no_array_write", 64'(wr_cnt - wr0), 64'd0);
        perf_wbs++;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   w, budget;
        bit   hs;

        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 1'b0;
        bus.cmd_set    = '0;
        bus.cmd_way    = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rlast  = 1'b0;
        bus.mem_wready = 1'b0;

        #12;
        chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("reset_strobes", 64'({bus.done, bus.err, bus.da_read, bus.da_write,
                                  bus.mem_rready, bus.mem_wvalid, bus.mem_wlast}), 64'd0);
        chk("reset_addr", 64'({bus.da_set_index, bus.da_way, bus.da_block_offset,
                               bus.da_byte_offset}), 64'd0);
        chk("reset_data", 64'({bus.mem_wdata, bus.da_write_data}), 64'd0);
`ifdef LINE_XFER_PERF_EN
        chk("reset_perf", 64'({perf_fill_cnt, perf_wb_cnt, perf_stall_cnt}), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        //            op set way rlast stall_w len bub base     err
        tbl.push_back(mk(0,   5, 2, 15,  -1,   0,  0, 'h100,   0));
        tbl.push_back(mk(1, 127, 3, 15,  -1,   0,  0, 'hA000,  0));
        tbl.push_back(mk(1,  10, 1, 15,   7,   5,  0, -1,      0));
        tbl.push_back(mk(0,  33, 0,  9,  -1,   0,  0, -1,      1));
        tbl.push_back(mk(0,  33, 1, 15,  -1,   0,  1, -1,      0));
        tbl.push_back(mk(1,   5, 2, 15,   0,   2,  0, -1,      0));
        tbl.push_back(mk(0,  64, 0,  0,  -1,   0,  0, -1,      1));
        tbl.push_back(mk(1,  33, 0, 15,  15,   3,  0, -1,      0));
        for (int r = 0; r < 10; r++) begin
            v.op         = 1'($urandom_range(0, 1));
            v.set        = int'($urandom_range(0, 127));
            v.way        = int'($urandom_range(0, 3));
            v.rlast_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 15;
            v.stall_word = int'($urandom_range(0, 15));
            v.stall_len  = int'($urandom_range(0, 4));
            v.bubbles    = 1'b1;
            v.base       = v.op ? int'($urandom_range(0, 32'h0FFF_FFFF)) : -1;
            v.exp_err    = !v.op && (v.rlast_beat != 15);
            tbl.push_back(v);
        end

        foreach (tbl[n]) begin
            if (tbl[n].op) run_wb(tbl[n]);
            else           run_fill(tbl[n]);
        end

        // Abort a writeback while word 6 is being read.
        preload(9 * 4 + 1, 'hC000);
        v = mk(1, 9, 1, 15, -1, 0, 0, -1, 0);
        send_cmd(v);
        bus.mem_wready = 1'b1;
        w = 0;
        budget = 0;
        while (w < 6 && budget < 100) begin
            @(negedge clk);
            hs = bus.mem_wvalid;
            @(posedge clk);
            #1;
            if (hs) w++;
            budget++;
        end
        bus.mem_wready = 1'b0;
        chk("abort_pre_busy", 64'({bus.da_read, bus.da_block_offset}), 64'({1'b1, 6'd24}));
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("abort_strobes", 64'({bus.done, bus.err, bus.da_read, bus.da_write,
                                  bus.mem_rready, bus.mem_wvalid, bus.mem_wlast}), 64'd0);
        chk("abort_addr", 64'({bus.da_set_index, bus.da_way, bus.da_block_offset}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        perf_fills  = 0;
        perf_wbs    = 0;
        perf_stalls = 0;
        @(posedge clk);
        #1;
        chk("post_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        run_fill(mk(0, 20, 0, 15, -1, 0, 0, -1, 0));
        run_fill(mk(0, 21, 3, 15, -1, 0, 1, -1, 0));
        run_wb(mk(1, 20, 0, 15, 4, 3, 0, -1, 0));
`ifdef LINE_XFER_PERF_EN
        chk("perf_fill_cnt", 64'(perf_fill_cnt), 64'(perf_fills));
        chk("perf_wb_cnt", 64'(perf_wb_cnt), 64'(perf_wbs));
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(perf_stalls));
`endif
        chk("no_read_write_overlap", 64'(both_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_line_xfer.md
Name: cache_line_xfer

Overview:
- Bulk initiator for the cache data array.
- Moves one full 64-byte line (16 x 32-bit words) between the data array and the memory-side bus:
  - FILL: memory beats are written into a set/way.
  - WRITEBACK: a set/way is read out and streamed to memory.
- Sits between the cache controller FSM (command side) and the data array's single read/write port.

Parameters:
- SET_BITS, 7, set index width (128 sets)
- WAY_BITS, 2, way select width (4-way)
- WORDS_PER_LINE, 16, 32-bit words per line; must be a power of two

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0 = FILL, 1 = WRITEBACK
- cmd_set  in  SET_BITS  target set
- cmd_way  in  WAY_BITS  target way
- done  out  1  one-cycle pulse when a line transfer completes
- err  out  1  sticky framing error; cleared on next command accept
- da_set_index  out  SET_BITS  data array set
- da_way  out  WAY_BITS  data array way
- da_block_offset  out  6  byte offset within line = word_idx*4
- da_byte_offset  out  2  always 0
- da_write_data  out  32  fill data to array
- da_read_data  in  32  array read data, valid the cycle after da_read
- da_write  out  1  array write strobe
- da_read  out  1  array read strobe
- mem_rvalid  in  1  fill beat valid
- mem_rready  out  1  fill beat accept
- mem_rdata  in  32  fill beat data
- mem_rlast  in  1  last fill beat marker
- mem_wvalid  out  1  writeback beat valid
- mem_wready  in  1  writeback beat accept
- mem_wdata  out  32  writeback beat data
- mem_wlast  out  1  high on beat WORDS_PER_LINE-1

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. State IDLE, word_idx = 0.
- IDLE:
  - On cmd_valid && cmd_ready, latch op/set/way, clear err, set word_idx = 0.
  - Go to FILL if op = 0, else go to WB_RD.
- FILL:
  - mem_rready = 1.
  - On each mem_rvalid, in the same cycle, drive da_write = 1, da_write_data = mem_rdata, da_block_offset = word_idx<<2.
  - Then increment word_idx.
  - On beat WORDS_PER_LINE-1, go to DONE.
  - A beat with mem_rlast != (word_idx == WORDS_PER_LINE-1) sets err.
  - The transfer always counts exactly WORDS_PER_LINE beats; it does not truncate early.
- WB_RD:
  - Assert da_read for one cycle at the current word_idx, then go to WB_CAP.
- WB_CAP:
  - Capture da_read_data into wdata_q (the 1-cycle array read latency), then go to WB_SEND.
- WB_SEND:
  - mem_wvalid = 1, mem_wdata = wdata_q, mem_wlast = (word_idx == WORDS_PER_LINE-1).
  - Hold all of these stable until mem_wready.
  - On handshake: if last word go to DONE, else increment word_idx and go to WB_RD.
- DONE:
  - done = 1 for one cycle, then go to IDLE.
- Throughput: FILL 1 word/cycle; WRITEBACK 3 cycles/word minimum.
- da_read and da_write are never asserted in the same cycle. Both are 0 outside FILL/WB_RD.
- word_idx is log2(WORDS_PER_LINE) bits wide. It wraps to 0 only through DONE/IDLE, never mid-transfer.
- cmd_valid outside IDLE is ignored (cmd_ready = 0). No queueing.
- Asserting rst_n low mid-transfer aborts immediately to reset values. Partially written lines are not rolled back; the controller must invalidate the line.
- mem_rvalid while not in FILL is ignored (mem_rready = 0).

Optional Feature:
- Macro LINE_XFER_PERF_EN.
- Defined:
  - Adds two 16-bit saturating counters, fill_cnt and wb_cnt, incremented at DONE per op.
  - Adds a 16-bit stall_cnt, incremented each WB_SEND cycle with mem_wready = 0.
  - These are exposed as outputs perf_fill_cnt, perf_wb_cnt, perf_stall_cnt. All reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package cache_pkg holds:
  - SET_BITS, WAY_BITS, WORDS_PER_LINE, WORD_BITS = 32, BLOCK_BYTES = 64
  - enum xfer_op_t {OP_FILL, OP_WRITEBACK}
  - enum xfer_state_t {IDLE, FILL, WB_RD, WB_CAP, WB_SEND, DONE}
- One natural sub-module: cache_line_xfer_perf, holding the saturating counters. It is instantiated only under LINE_XFER_PERF_EN.

Test Plan:
- FILL set 5, way 2, beats 0x100..0x10F back-to-back with rlast on beat 15 -> 16 da_write pulses at offsets 0,4,...,60 with matching data; done pulses 1 cycle after the last beat; err = 0.
- WRITEBACK set 127, way 3, array model preloaded with 0xA000+i, mem_wready always 1 -> mem_wdata sequence 0xA000..0xA00F; mem_wlast only on the 16th beat; done once.
- WRITEBACK with mem_wready held low 5 cycles on word 7 -> mem_wvalid and mem_wdata stable for the whole stall; no extra da_read; sequence intact.
- FILL with rlast asserted on beat 9 -> err = 1 sticky, 16 writes still performed; next cmd accept clears err.
- rst_n pulsed low during word 6 of a writeback -> all outputs at reset values asynchronously; cmd_ready = 1 after release; a new FILL then completes normally.
- Under LINE_XFER_PERF_EN: 2 fills + 1 writeback with 3 stall cycles -> perf_fill_cnt = 2, perf_wb_cnt = 1, perf_stall_cnt = 3.
